// File: rtl/raytracing_line_scheduler.sv
// ----------------------------------------------------------------------------
// raytracing_line_scheduler
//
// Steps the raytracing worker bank through a frame one screen line at a time.
// For each line it registers the per-line operands, holds the workers in
// reset for one cycle, lets them run, and then drains their colour buffers
// to the frame-buffer writer as a pixel stream in screen-x order.
//
// Ports
//   clk, rst_        clock, synchronous active-low reset
//   start            1-cycle request to render one frame (only seen in IDLE)
//   sphere           scene sphere, captured when start is accepted
//   frame_done       1-cycle pulse after the last pixel of the frame is taken
//   sched_busy       high from accepted start until frame_done
//   activate         common worker activate, low = workers held in reset
//   pixel_start_x    per-worker first screen x, centred (12 bits per worker)
//   pixel_y          current row, centred
//   pixel_y_sqrd     pixel_y squared
//   doty_r           pixel_y * sphere.y
//   sphere_y_sqrd    (sphere.y squared) >>> FP_B
//   sphere_out       captured sphere, broadcast to all workers
//   worker_busy      busy flag from each worker
//   worker_buf       colour buffers, worker-major then job-minor, 12 bits each
//   out_valid/out_ready/out_x/out_y/out_color   pixel stream
//   dbg_state        current scheduler state
//
// Pixel stream handshake: a pixel transfers on a rising clock edge where
// out_valid and out_ready are both high. Once out_valid is raised, out_x,
// out_y and out_color hold steady until that transfer. out_valid depends on
// the state register only, never on out_ready.
// ----------------------------------------------------------------------------
package Types;
    typedef logic [11:0] Color;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
        logic        [15:0] r;
    } Sphere;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } sched_state_e;
endpackage

module raytracing_line_scheduler #(
    parameter int N_WORKERS   = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int FP_B        = 4,
    parameter int PX_Y_B      = 10,
    parameter int PX_Y_SQRD_B = 17,
    parameter int DOT_Y_B     = 26,
    parameter int S_Y_SQRD_B  = 32
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         start,
    input  Types::Sphere                 sphere,
    output logic                         frame_done,
    output logic                         sched_busy,
    output logic                         activate,
    output logic [N_WORKERS*12-1:0]      pixel_start_x,
    output logic signed [PX_Y_B-1:0]     pixel_y,
    output logic [PX_Y_SQRD_B-1:0]       pixel_y_sqrd,
    output logic signed [DOT_Y_B-1:0]    doty_r,
    output logic [S_Y_SQRD_B-1:0]        sphere_y_sqrd,
    output Types::Sphere                 sphere_out,
    input  logic [N_WORKERS-1:0]         worker_busy,
    input  logic [SCREEN_W*12-1:0]       worker_buf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [9:0]                   out_x,
    output logic [8:0]                   out_y,
    output Types::Color                  out_color,
    output Types::sched_state_e          dbg_state
);
    import Types::*;

    localparam int JOBS    = SCREEN_W / N_WORKERS;
    localparam int W_B     = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int J_B     = (JOBS > 1) ? $clog2(JOBS) : 1;
    localparam int IDX_B   = $clog2(SCREEN_W * 12);
    localparam int PY_SQ_B = 2 * PX_Y_B;

    sched_state_e            state, state_next;
    logic [8:0]              row;
    logic [9:0]              x_cnt;
    logic [W_B-1:0]          w_cnt;
    logic [J_B-1:0]          j_cnt;
    logic                    seen;
    logic                    fire;
    logic                    last_px;
    logic                    last_row;
    logic signed [PX_Y_B-1:0] py_next;
    logic [IDX_B-1:0]        bit_base;

    assign fire     = out_valid & out_ready;
    assign last_px  = (x_cnt == 10'(SCREEN_W - 1));
    assign last_row = (row == 9'(SCREEN_H - 1));
    assign py_next  = PX_Y_B'($signed({1'b0, row})) - PX_Y_B'(SCREEN_H / 2);

    // Pixel x lives in worker x % N_WORKERS, job slot x / N_WORKERS.
    assign bit_base  = IDX_B'((int'(w_cnt) * JOBS + int'(j_cnt)) * 12);
    assign out_color = worker_buf[bit_base +: 12];
    assign out_x     = x_cnt;
    assign out_y     = row;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        activate   = 1'b0;
        out_valid  = 1'b0;
        sched_busy = 1'b1;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                sched_busy = 1'b0;
                if (start) state_next = S_PREP;
            end
            S_PREP: state_next = S_LAUNCH;
            S_LAUNCH: begin
                activate = 1'b1;
                if (&worker_busy) state_next = S_RUN;
            end
            S_RUN: begin
                activate = 1'b1;
                // Workers park in FINISHED once idle, so buffers are stable.
                if (seen && !(|worker_busy)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                activate  = 1'b1;
                out_valid = 1'b1;
                if (fire && last_px) state_next = last_row ? S_DONE : S_PREP;
            end
            S_DONE: begin
                sched_busy = 1'b0;
                frame_done = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            row           <= '0;
            x_cnt         <= '0;
            w_cnt         <= '0;
            j_cnt         <= '0;
            seen          <= 1'b0;
            sphere_out    <= '0;
            pixel_start_x <= '0;
            pixel_y       <= '0;
            pixel_y_sqrd  <= '0;
            doty_r        <= '0;
            sphere_y_sqrd <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sphere_out <= sphere;
                        row        <= '0;
                    end
                end
                S_PREP: begin
                    pixel_y       <= py_next;
                    pixel_y_sqrd  <= PX_Y_SQRD_B'(PY_SQ_B'(py_next) * PY_SQ_B'(py_next));
                    doty_r        <= DOT_Y_B'(py_next) * DOT_Y_B'(sphere_out.y);
                    sphere_y_sqrd <= S_Y_SQRD_B'((32'(sphere_out.y) * 32'(sphere_out.y)) >>> FP_B);
                    for (int w = 0; w < N_WORKERS; w++) begin
                        pixel_start_x[w*12 +: 12] <= 12'(w) - 12'(SCREEN_W / 2);
                    end
                    seen  <= 1'b0;
                    x_cnt <= '0;
                    w_cnt <= '0;
                    j_cnt <= '0;
                end
                S_LAUNCH: begin
                    if (&worker_busy) seen <= 1'b1;
                end
                S_DRAIN: begin
                    if (fire) begin
                        if (last_px) begin
                            x_cnt <= '0;
                            w_cnt <= '0;
                            j_cnt <= '0;
                            if (!last_row) row <= row + 9'd1;
                        end else begin
                            x_cnt <= x_cnt + 10'd1;
                            if (w_cnt == W_B'(N_WORKERS - 1)) begin
                                w_cnt <= '0;
                                j_cnt <= j_cnt + J_B'(1);
                            end else begin
                                w_cnt <= w_cnt + W_B'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_raytracing_line_scheduler.sv
// ----------------------------------------------------------------------------
// tb_raytracing_line_scheduler
//
// Two scheduler instances share clock and reset: a small one (8x2 screen,
// 4 workers, stub workers) that renders whole frames, and one with default
// parameters used to check the per-line operand arithmetic.
// ----------------------------------------------------------------------------
module tb_raytracing_line_scheduler;
    import Types::*;

    localparam int SN = 4;
    localparam int SW = 8;
    localparam int SH = 2;
    localparam int SJ = SW / SN;

    // clock / reset
    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // small instance
    logic               s_start;
    Sphere              s_sphere;
    logic               s_frame_done, s_sched_busy, s_activate;
    logic [SN*12-1:0]   s_psx;
    logic signed [9:0]  s_py;
    logic [16:0]        s_pysq;
    logic signed [25:0] s_doty;
    logic [31:0]        s_ysq;
    Sphere              s_sph_out;
    logic [SN-1:0]      s_busy;
    logic [SW*12-1:0]   s_buf;
    logic               s_valid, s_ready;
    logic [9:0]         s_x;
    logic [8:0]         s_y;
    Color               s_color;
    sched_state_e       s_state;

    // default instance
    logic               d_start;
    Sphere              d_sphere;
    logic               d_frame_done, d_sched_busy, d_activate;
    logic [16*12-1:0]   d_psx;
    logic signed [9:0]  d_py;
    logic [16:0]        d_pysq;
    logic signed [25:0] d_doty;
    logic [31:0]        d_ysq;
    Sphere              d_sph_out;
    logic [15:0]        d_busy;
    logic [640*12-1:0]  d_buf;
    logic               d_valid, d_ready;
    logic [9:0]         d_x;
    logic [8:0]         d_y;
    Color               d_color;
    sched_state_e       d_state;

    raytracing_line_scheduler #(.N_WORKERS(SN), .SCREEN_W(SW), .SCREEN_H(SH)) dut_s (
        .clk(clk), .rst_(rst_), .start(s_start), .sphere(s_sphere),
        .frame_done(s_frame_done), .sched_busy(s_sched_busy), .activate(s_activate),
        .pixel_start_x(s_psx), .pixel_y(s_py), .pixel_y_sqrd(s_pysq), .doty_r(s_doty),
        .sphere_y_sqrd(s_ysq), .sphere_out(s_sph_out), .worker_busy(s_busy),
        .worker_buf(s_buf), .out_valid(s_valid), .out_ready(s_ready), .out_x(s_x),
        .out_y(s_y), .out_color(s_color), .dbg_state(s_state)
    );

    raytracing_line_scheduler dut_d (
        .clk(clk), .rst_(rst_), .start(d_start), .sphere(d_sphere),
        .frame_done(d_frame_done), .sched_busy(d_sched_busy), .activate(d_activate),
        .pixel_start_x(d_psx), .pixel_y(d_py), .pixel_y_sqrd(d_pysq), .doty_r(d_doty),
        .sphere_y_sqrd(d_ysq), .sphere_out(d_sph_out), .worker_busy(d_busy),
        .worker_buf(d_buf), .out_valid(d_valid), .out_ready(d_ready), .out_x(d_x),
        .out_y(d_y), .out_color(d_color), .dbg_state(d_state)
    );

    // environment knobs
    logic [11:0] salt = '0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: 1,0,0,1 pattern
    int stub_delay = 1;
    int stub_len   = 2;
    int stub_cnt   = 0;
    int done_cnt   = 0;

    // scoreboard: {x, y, colour}
    logic [30:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // stub workers: busy rises stub_delay cycles after activate, falls staggered;
    // buffer holds colour (x + 16*y) ^ salt for the row the scheduler presents
    initial begin
        int yy;
        s_busy = '0;
        s_buf  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!s_activate) stub_cnt = 0;
            else             stub_cnt++;
            for (int w = 0; w < SN; w++)
                s_busy[w] = s_activate && (stub_cnt >= stub_delay) &&
                            (stub_cnt < stub_delay + 1 + stub_len + w);
            yy = int'(s_py) + SH / 2;
            for (int w = 0; w < SN; w++)
                for (int j = 0; j < SJ; j++)
                    s_buf[(w*SJ + j)*12 +: 12] = 12'(w + SN*j + 16*yy) ^ salt;
        end
    end

    // ready driver
    initial begin
        logic [3:0] pat;
        int pi;
        pat = 4'b1001;
        pi  = 0;
        s_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       s_ready = 1'($urandom_range(0, 1));
                2: begin
                    s_ready = pat[pi];
                    pi = (pi + 1) % 4;
                end
                default: s_ready = 1'b1;
            endcase
        end
    end

    // stream monitor
    int low_run = 0, launch_run = 0, valid_run = 0;
    always @(negedge clk) begin
        if (!rst_) begin
            low_run    = 0;
            launch_run = 0;
            valid_run  = 0;
        end else begin
            if (s_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d color=%0h, expected none",
                             s_x, s_y, s_color);
                end else begin
                    check("pixel", {s_x, s_y, s_color}, exp_q[0]);
                    if (s_ready) void'(exp_q.pop_front());
                end
                valid_run++;
            end else if (valid_run != 0) begin
                if (ready_mode == 0) check("drain_len", valid_run, SW);
                valid_run = 0;
            end
            if (s_sched_busy && !s_activate) low_run++;
            else if (s_activate && low_run != 0) begin
                check("activate_low_len", low_run, 1);
                low_run = 0;
            end
            if (s_state == S_LAUNCH) launch_run++;
            else if (launch_run != 0) begin
                check("launch_len", launch_run, stub_delay);
                launch_run = 0;
            end
            if (s_frame_done) begin
                done_cnt++;
                check("queue_empty_at_done", exp_q.size(), 0);
                check("busy_low_at_done", s_sched_busy, 0);
            end
        end
    end

    task automatic fill_expected(input logic [11:0] salt_i);
        exp_q.delete();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                exp_q.push_back({10'(x), 9'(y), 12'(x + 16*y) ^ salt_i});
    endtask

    task automatic run_frame(input logic [11:0] salt_i, input int mode, input int dly,
                             input int len, input bit poke_run);
        bit got, poked;
        int done_before;
        salt = salt_i; ready_mode = mode; stub_delay = dly; stub_len = len;
        fill_expected(salt_i);
        done_before = done_cnt;
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        got = 0; poked = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (s_frame_done) got = 1;
            if (poke_run && !poked && s_state == S_RUN) begin
                s_start = 1'b1;
                poked = 1;
            end else begin
                s_start = 1'b0;
            end
        end
        s_start = 1'b0;
        check("frame_done_seen", got, 1);
        if (poke_run) check("start_poked_in_run", poked, 1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_frame", s_state, S_IDLE);
        check("one_done_pulse", done_cnt - done_before, 1);
        check("all_pixels_sent", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic op_check(input logic signed [15:0] sy, input logic signed [9:0] epy,
                            input logic [16:0] epysq, input logic signed [25:0] edoty,
                            input logic [31:0] eysq);
        Sphere sph;
        rst_ = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        sph = '{x: 16'sd7, y: sy, z: -16'sd5, r: 16'd50};
        d_sphere = sph;
        d_start  = 1'b1;
        @(posedge clk);
        #1 d_start = 1'b0;
        d_sphere = ~sph;  // must not reach sphere_out
        repeat (3) @(posedge clk);
        #1;
        check("op_state_launch", d_state, S_LAUNCH);
        check("op_activate", d_activate, 1);
        check("op_pixel_y", d_py, epy);
        check("op_pixel_y_sqrd", d_pysq, epysq);
        check("op_doty_r", d_doty, edoty);
        check("op_sphere_y_sqrd", d_ysq, eysq);
        check("op_sphere_out", d_sph_out, sph);
        check("op_start_x_w0", d_psx[11:0], 12'hEC0);     // -320
        check("op_start_x_w15", d_psx[191:180], 12'hECF); // -305
    endtask

    typedef struct {
        logic signed [15:0] sy;
        logic signed [9:0]  py;
        logic [16:0]        pysq;
        logic signed [25:0] doty;
        logic [31:0]        ysq;
    } op_vec_t;

    initial begin
        op_vec_t vecs[5];
        bit reached;
        int syi;

        vecs[0] = '{sy: 16'sd100,    py: -10'sd240, pysq: 17'd57600, doty: -26'sd24000,   ysq: 32'd625};
        vecs[1] = '{sy: -16'sd37,    py: -10'sd240, pysq: 17'd57600, doty: 26'sd8880,     ysq: 32'd85};
        vecs[2] = '{sy: 16'sd0,      py: -10'sd240, pysq: 17'd57600, doty: 26'sd0,        ysq: 32'd0};
        vecs[3] = '{sy: 16'sd32767,  py: -10'sd240, pysq: 17'd57600, doty: -26'sd7864080, ysq: 32'd67104768};
        vecs[4] = '{sy: -16'sd32768, py: -10'sd240, pysq: 17'd57600, doty: 26'sd7864320,  ysq: 32'd67108864};

        s_start = 1'b0; d_start = 1'b0;
        s_sphere = '0;  d_sphere = '0;
        d_busy = '0; d_buf = '0; d_ready = 1'b1;

        // reset held 3 cycles with start asserted
        rst_ = 1'b0; s_start = 1'b1; d_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_activate", s_activate, 0);
        check("rst_out_valid", s_valid, 0);
        check("rst_sched_busy", s_sched_busy, 0);
        check("rst_frame_done", s_frame_done, 0);
        check("rst_state", s_state, S_IDLE);
        check("rst_pixel_y", d_py, 0);
        check("rst_doty", d_doty, 0);
        check("rst_d_busy", d_sched_busy, 0);
        s_start = 1'b0; d_start = 1'b0;
        @(posedge clk);
        #1 rst_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("start_in_reset_ignored", s_state, S_IDLE);
        check("start_in_reset_ignored_d", d_state, S_IDLE);

        // operand table, then random sphere.y against plain arithmetic
        for (int i = 0; i < 5; i++)
            op_check(vecs[i].sy, vecs[i].py, vecs[i].pysq, vecs[i].doty, vecs[i].ysq);
        for (int i = 0; i < 4; i++) begin
            syi = int'($urandom_range(0, 65535)) - 32768;
            op_check(16'(syi), -10'sd240, 17'd57600, 26'(-240 * syi), 32'((syi * syi) >> 4));
        end

        // whole frames on the small instance
        run_frame(12'h000, 0, 1, 2, 0);  // plain raster, colour = x + 16*y
        run_frame(12'h000, 2, 1, 2, 0);  // 1,0,0,1 backpressure
        run_frame(12'h5A5, 0, 2, 6, 1);  // start poked while in RUN
        run_frame(12'h0F0, 0, 5, 1, 0);  // busy rises 5 cycles late
        for (int i = 0; i < 6; i++)
            run_frame(12'($urandom_range(0, 4095)), int'($urandom_range(0, 2)),
                      int'($urandom_range(1, 4)), int'($urandom_range(0, 5)), 0);

        // reset in the middle of DRAIN, then a fresh frame from row 0
        salt = 12'h123; ready_mode = 1; stub_delay = 1; stub_len = 1;
        fill_expected(salt);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        reached = 0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            @(negedge clk);
            if (s_state == S_DRAIN && exp_q.size() <= 12) reached = 1;
        end
        check("reached_mid_drain", reached, 1);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        check("mid_drain_rst_state", s_state, S_IDLE);
        check("mid_drain_rst_valid", s_valid, 0);
        check("mid_drain_rst_busy", s_sched_busy, 0);
        check("mid_drain_rst_activate", s_activate, 0);
        rst_ = 1'b1;
        exp_q.delete();
        run_frame(12'h321, 1, 2, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
